// File: rtl/wiring_driver.sv
// Queues trigger masks, pulses the wiring block, waits for quiescence or timeout, captures, clears, then responds.
// Pop to rsp_valid takes 4 cycles with immediate quiescence; cmd_ready = !full, and the response is held until rsp_ready.
module wiring_driver #(
    parameter int INPUT_WIDTH  = 1,
    parameter int OUTPUT_WIDTH = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [INPUT_WIDTH-1:0]  cmd_mask,
    output logic [INPUT_WIDTH-1:0]  wiring_in,
    input  logic                    wiring_running,
    input  logic [OUTPUT_WIDTH-1:0] wiring_out,
    output logic                    wiring_logic_reset,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUTPUT_WIDTH-1:0] rsp_out,
    output logic [7:0]              rsp_cycles,
    output logic                    rsp_timeout,
    output logic                    busy
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_SETTLE,
        S_CAPTURE,
        S_CLEAR,
        S_RESPOND
    } state_t;

    logic [INPUT_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [INPUT_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [INPUT_WIDTH-1:0] fifo_head;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    to_flag_q, to_flag_d;
    logic [INPUT_WIDTH-1:0]  wiring_in_q, wiring_in_d;
    logic                    wlr_q, wlr_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [OUTPUT_WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic [7:0]              rsp_cycles_q, rsp_cycles_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    busy_q, busy_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign fifo_push  = cmd_valid && !fifo_full;
    assign cmd_ready  = !fifo_full;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q[AW-1:0]] = cmd_mask;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        to_flag_d     = to_flag_q;
        wiring_in_d   = '0;
        wlr_d         = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_out_d     = rsp_out_q;
        rsp_cycles_d  = rsp_cycles_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    wiring_in_d = fifo_head;
                    state_d     = S_FIRE;
                end
            end
            S_FIRE: begin
                cnt_d     = 8'd0;
                to_flag_d = 1'b0;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (!wiring_running) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Stop exactly at TIMEOUT so the count saturates instead of wrapping.
                    if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                        to_flag_d = 1'b1;
                        state_d   = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                rsp_out_d     = wiring_out;
                rsp_cycles_d  = cnt_q;
                rsp_timeout_d = to_flag_q;
                wlr_d         = 1'b1;
                state_d       = S_CLEAR;
            end
            S_CLEAR: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem_q    <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            to_flag_q     <= 1'b0;
            wiring_in_q   <= '0;
            wlr_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_out_q     <= '0;
            rsp_cycles_q  <= 8'd0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_flag_q     <= to_flag_d;
            wiring_in_q   <= wiring_in_d;
            wlr_q         <= wlr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_out_q     <= rsp_out_d;
            rsp_cycles_q  <= rsp_cycles_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign wiring_in          = wiring_in_q;
    assign wiring_logic_reset = wlr_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_out            = rsp_out_q;
    assign rsp_cycles         = rsp_cycles_q;
    assign rsp_timeout        = rsp_timeout_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_wiring_driver.sv
// Directed bench for wiring_driver with a small behavioural wiring block that stays busy run_len cycles after a pulse.
module tb_wiring_driver;

    localparam int IW = 4;
    localparam int OW = 4;
    localparam int FD = 4;
    localparam int TO = 5;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_mask  = '0;
    logic [IW-1:0] wiring_in;
    logic          wiring_running;
    logic [OW-1:0] wiring_out;
    logic          wiring_logic_reset;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [OW-1:0] rsp_out;
    logic [7:0]    rsp_cycles;
    logic          rsp_timeout;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    run_len = 8'd0;
    logic [7:0]    run_cnt;
    logic [OW-1:0] model_out;
    int            pulse_cnt = 0;
    int            clear_cnt = 0;

    wiring_driver #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .FIFO_DEPTH  (FD),
        .TIMEOUT     (TO)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_mask          (cmd_mask),
        .wiring_in         (wiring_in),
        .wiring_running    (wiring_running),
        .wiring_out        (wiring_out),
        .wiring_logic_reset(wiring_logic_reset),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_out           (rsp_out),
        .rsp_cycles        (rsp_cycles),
        .rsp_timeout       (rsp_timeout),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Wiring block model: a pulse latches its mask as the output and runs for run_len cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= 8'd0;
            model_out <= '0;
        end else if (wiring_logic_reset) begin
            run_cnt   <= 8'd0;
            model_out <= '0;
        end else if (wiring_in != '0) begin
            run_cnt   <= run_len;
            model_out <= wiring_in;
        end else if (run_cnt != 8'd0) begin
            run_cnt <= run_cnt - 8'd1;
        end
    end
    assign wiring_running = (run_cnt != 8'd0);
    assign wiring_out     = model_out;

    always @(posedge clk) begin
        if (wiring_in != '0) pulse_cnt <= pulse_cnt + 1;
        if (wiring_logic_reset) clear_cnt <= clear_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] m);
        int w = 0;
        while (!cmd_ready && w < 50) begin
            step();
            w++;
        end
        chk("push_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_mask  = m;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int e_out, input int e_cyc, input int e_to,
                              input int e_pulses, input int e_clears, input int stall);
        int w = 0;
        while (!rsp_valid && w < 100) begin
            step();
            w++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_out"}, 32'(rsp_out), 32'(e_out));
        chk({tag, "_cycles"}, 32'(rsp_cycles), 32'(e_cyc));
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(e_to));
        chk({tag, "_pulses"}, 32'(pulse_cnt), 32'(e_pulses));
        chk({tag, "_clears"}, 32'(clear_cnt), 32'(e_clears));
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 1);
            chk({tag, "_hold_out"}, 32'(rsp_out), 32'(e_out));
            chk({tag, "_hold_cycles"}, 32'(rsp_cycles), 32'(e_cyc));
            chk({tag, "_hold_timeout"}, 32'(rsp_timeout), 32'(e_to));
            chk({tag, "_hold_no_pulse"}, 32'(wiring_in), 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, 32'(rsp_valid), 0);
    endtask

    task automatic check_all_clear(input string tag);
        chk({tag, "_wiring_in"}, 32'(wiring_in), 0);
        chk({tag, "_logic_reset"}, 32'(wiring_logic_reset), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_out"}, 32'(rsp_out), 0);
        chk({tag, "_rsp_cycles"}, 32'(rsp_cycles), 0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then a command offered before release lands on the first edge.
        #1 rst_n = 1'b0;
        #1 check_all_clear("reset");
        run_len   = 8'd3;
        cmd_mask  = 4'h1;
        cmd_valid = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        chk("ready_after_release", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        chk("first_idle_no_pulse", 32'(wiring_in), 0);
        chk("first_idle_busy", 32'(busy), 0);
        step();
        chk("first_fire_pulse", 32'(wiring_in), 1);
        chk("first_fire_busy", 32'(busy), 1);
        step();
        chk("first_pulse_ends", 32'(wiring_in), 0);
        expect_rsp("mask1", 1, 3, 0, 1, 1, 0);

        // Mask 0 with quiescent wiring: rsp_valid exactly 4 cycles after the pop edge.
        push(4'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mask0_latency_low", 32'(rsp_valid), 0);
            chk("mask0_no_pulse", 32'(wiring_in), 0);
            chk("mask0_clear_slot", 32'(wiring_logic_reset), (i == 3) ? 1 : 0);
        end
        step();
        chk("mask0_latency_high", 32'(rsp_valid), 1);
        expect_rsp("mask0", 0, 0, 0, 1, 2, 0);

        // Wiring never settles: timeout after TIMEOUT cycles.
        run_len = 8'd100;
        push(4'h5);
        expect_rsp("timeout", 5, TO, 1, 2, 3, 0);

        // Fill the FIFO while the first response is stalled; responses come back in push order.
        run_len = 8'd2;
        for (int k = 0; k < FD + 1; k++) begin
            chk("fill_ready", 32'(cmd_ready), 1);
            cmd_valid = 1'b1;
            cmd_mask  = 4'(k + 1);
            step();
        end
        cmd_valid = 1'b0;
        chk("fill_full", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_mask  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_blocks", 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < FD + 1; k++) begin
            expect_rsp("order", k + 1, 2, 0, 3 + k, 4 + k, 0);
        end
        for (int k = 0; k < 10; k++) step();
        chk("order_no_extra_rsp", 32'(rsp_valid), 0);
        chk("order_idle", 32'(busy), 0);
        chk("order_pulse_total", 32'(pulse_cnt), 7);

        // Response stalled 10 cycles with another command queued behind it.
        push(4'h6);
        push(4'h7);
        expect_rsp("stall", 6, 2, 0, 8, 9, 10);
        expect_rsp("after_stall", 7, 2, 0, 9, 10, 0);

        // Reset during SETTLE with two commands queued.
        run_len = 8'd200;
        push(4'h8);
        push(4'h9);
        push(4'hA);
        step();
        step();
        chk("settle_busy", 32'(busy), 1);
        chk("settle_no_pulse", 32'(wiring_in), 0);
        rst_n = 1'b0;
        #1 check_all_clear("mid_reset");
        step();
        rst_n = 1'b1;
        chk("mid_reset_ready", 32'(cmd_ready), 1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("discard_no_rsp", 32'(rsp_valid), 0);
            chk("discard_idle", 32'(busy), 0);
        end
        chk("discard_no_pulse", 32'(pulse_cnt), 10);

        run_len = 8'd0;
        push(4'h3);
        expect_rsp("post_reset", 3, 0, 0, 11, 11, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wiring_driver.md
WIRING_DRIVER -- requirements
Module: wiring_driver

Interface
REQ-001 Parameter INPUT_WIDTH, default 1: width of the wiring input bus and command mask.
REQ-002 Parameter OUTPUT_WIDTH, default 2: width of the wiring output bus and response data.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2: command FIFO entries.
REQ-004 Parameter TIMEOUT, default 255, range 1..255: maximum settle cycles per command.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  high when the FIFO can accept a command.
REQ-009 cmd_mask  input  INPUT_WIDTH  input triggers to pulse.
REQ-010 wiring_in  output  INPUT_WIDTH  trigger pulses to the wiring block's in port.
REQ-011 wiring_running  input  1  wiring block activity flag.
REQ-012 wiring_out  input  OUTPUT_WIDTH  wiring block outputs.
REQ-013 wiring_logic_reset  output  1  one-cycle clear of gate and output state.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  response consumed.
REQ-016 rsp_out  output  OUTPUT_WIDTH  captured wiring_out.
REQ-017 rsp_cycles  output  8  settle cycles counted.
REQ-018 rsp_timeout  output  1  settle ended by TIMEOUT, not by quiescence.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 Command FIFO SHALL push on cmd_valid && cmd_ready; cmd_ready = !full; a simultaneous push and pop at full SHALL NOT be accepted (cmd_ready depends on full only).
REQ-021 FSM states: IDLE, FIRE, SETTLE, CAPTURE, CLEAR, RESPOND; all outputs registered.
REQ-022 IDLE: FIFO non-empty -> pop head, load mask, go FIRE next cycle; empty -> stay.
REQ-023 FIRE: wiring_in = loaded mask for exactly one cycle; settle counter cleared to 0; -> SETTLE. wiring_in SHALL be 0 in every other state.
REQ-024 SETTLE: wiring_running low -> CAPTURE; else counter increments; counter reaching TIMEOUT with wiring_running still high -> CAPTURE with timeout flag set.
REQ-025 CAPTURE: rsp_out <= wiring_out, rsp_cycles <= counter, rsp_timeout <= flag; -> CLEAR.
REQ-026 CLEAR: wiring_logic_reset = 1 for exactly one cycle; -> RESPOND.
REQ-027 RESPOND: rsp_valid = 1; rsp_out/rsp_cycles/rsp_timeout stable until rsp_valid && rsp_ready; then rsp_valid drops and FSM -> IDLE.
REQ-028 Mask of zero SHALL still run the full sequence (rsp_cycles 0 when wiring_running already low).
REQ-029 Minimum command latency, FIFO pop to rsp_valid, with immediate quiescence: 4 cycles (FIRE, SETTLE, CAPTURE, CLEAR).
REQ-030 Commands SHALL be processed strictly in order, one at a time; FIFO pushes continue during any state.
REQ-031 rsp_cycles SHALL saturate at TIMEOUT; counter SHALL never wrap.

Reset
REQ-032 reset low SHALL immediately clear: FSM to IDLE, FIFO empty, wiring_in 0, wiring_logic_reset 0, rsp_valid 0, rsp_out 0, rsp_cycles 0, rsp_timeout 0, busy 0; cmd_ready 1 after release.
REQ-033 Reset mid-command SHALL discard the in-flight command and all queued commands; no response is produced.
REQ-034 After reset release the first command SHALL be accepted on the first clock edge.

Verification
REQ-035 Mask 1, wiring model running high 3 cycles after pulse -> one-cycle wiring_in=1, rsp_cycles=3, rsp_timeout=0, rsp_out=model outputs, one wiring_logic_reset pulse before rsp_valid.
REQ-036 Model holds wiring_running high, TIMEOUT=5 -> rsp_cycles=5, rsp_timeout=1, then CLEAR and RESPOND as normal.
REQ-037 Push FIFO_DEPTH+1 commands back-to-back while rsp_ready=0 -> cmd_ready low after FIFO_DEPTH accepts (allowing for the first pop); responses return in push order.
REQ-038 Mask 0 with wiring_running low -> rsp_cycles=0, rsp_out=0, rsp_valid 4 cycles after pop.
REQ-039 rsp_ready held low 10 cycles in RESPOND -> rsp_* stable, no new wiring_in pulse until handshake.
REQ-040 Assert reset during SETTLE with 2 queued commands -> all outputs 0, busy 0, no response after release.
